// File: rtl/trojan_pkg.sv
// Shared types for the PPM transmitter:
// frame FSM states and frame length helper.
package trojan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      SPACE = 2'd2
   } state_e;

   function automatic int frame_len(
      input int sym_w,
      input int unit,
      input int gap
   );
      return (2 ** sym_w) * unit + gap;
   endfunction

endpackage

// File: rtl/trojan_ppm_tx_if.sv
// Symbol stream in, modulated pin and
// status out, for the PPM transmitter.
interface trojan_ppm_tx_if #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             enable;
   logic [SYM_W-1:0] sym;
   logic             out;
   logic             busy;
   logic             ovf;
   logic [LW-1:0]    level;

   modport master (
      output enable, sym,
      input  out, busy, ovf, level
   );

   modport slave (
      input  enable, sym,
      output out, busy, ovf, level
   );
endinterface

// File: rtl/sym_fifo.sv
// In-order symbol FIFO; a push while full
// succeeds only if a pop happens on the same edge.
module sym_fifo #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [SYM_W-1:0] din,
   output logic [SYM_W-1:0] dout,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [SYM_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic             do_push, do_pop;

   assign full    = (lvl_q == LW'(DEPTH));
   assign empty   = (lvl_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q];
   assign level   = lvl_q;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (do_push)
         wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      if (do_pop)
         rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      if (do_push && !do_pop)
         lvl_d = lvl_q + LW'(1);
      else if (do_pop && !do_push)
         lvl_d = lvl_q - LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
         if (do_push)
            mem_q[wr_q] <= din;
      end
   end

endmodule

// File: rtl/trojan_ppm_tx.sv
// Drains buffered symbols onto one pin as
// pulse-width frames: high (sym+1)*UNIT, then low.
module trojan_ppm_tx
   import trojan_pkg::*;
#(
   parameter int SYM_W = 2,
   parameter int DEPTH = 8,
   parameter int UNIT  = 4,
   parameter int GAP   = 4
) (
   input logic             clk,
   input logic             rst_all,
   trojan_ppm_tx_if.slave  bus
);

   localparam int FRAME = frame_len(SYM_W, UNIT, GAP);
   localparam int CW    = $clog2(FRAME) + 1;
   localparam int LW    = $clog2(DEPTH) + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    width_q, width_d;
   logic             out_q, ovf_q;
   logic             pop;
   logic [SYM_W-1:0] head;
   logic [LW-1:0]    lvl;
   logic             full, empty;

   sym_fifo #(
      .SYM_W (SYM_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst_all),
      .push  (bus.enable),
      .pop   (pop),
      .din   (bus.sym),
      .dout  (head),
      .level (lvl),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      width_d = width_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = PULSE;
               width_d = (CW'(head) + CW'(1)) * CW'(UNIT);
            end
         end
         PULSE: begin
            if (cnt_q == width_q - CW'(1))
               state_d = SPACE;
         end
         SPACE: begin
            if (cnt_q == CW'(FRAME - 1)) begin
               cnt_d = '0;
               // next frame starts with no idle clock
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = PULSE;
                  width_d = (CW'(head) + CW'(1)) * CW'(UNIT);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_all) begin
      if (rst_all) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         out_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         width_q <= width_d;
         out_q   <= (state_d == PULSE);
         if (bus.enable && full && !pop)
            ovf_q <= 1'b1;
      end
   end

   assign bus.out   = out_q;
   assign bus.ovf   = ovf_q;
   assign bus.level = lvl;
   assign bus.busy  = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_trojan_ppm_tx.sv
// Directed bench for trojan_ppm_tx: single
// frames, bursts, overflow, mid-frame reset.
module tb_trojan_ppm_tx;

   logic clk;
   logic rst_all;
   int   n_cmp;
   int   n_err;
   int   sq [16];

   trojan_ppm_tx_if #(.SYM_W(2), .DEPTH(8)) bus ();

   trojan_ppm_tx dut (
      .clk     (clk),
      .rst_all (rst_all),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_all    = 1'b1;
      bus.enable = 1'b0;
      bus.sym    = '0;
      #2;
      chk("rst_out", bus.out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_level", bus.level, 0);
      #1;
      rst_all = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // k counts edges from the first enabled edge
   task automatic run_burst(
      input int n,
      input int nacc,
      input int drop_k,
      input int peak_exp
   );
      int peak;
      int total;
      int f;
      int pos;
      logic eo;
      peak       = 0;
      total      = 20 * nacc + 3;
      bus.enable = 1'b1;
      bus.sym    = 2'(sq[0]);
      for (int k = 0; k <= total; k++) begin
         @(posedge clk);
         #1;
         if (k + 1 < n)
            bus.sym = 2'(sq[k+1]);
         else
            bus.enable = 1'b0;
         if (int'(bus.level) > peak)
            peak = int'(bus.level);
         if (k >= 1) begin
            f   = (k - 1) / 20;
            pos = (k - 1) % 20;
            eo  = (f < nacc) && (pos < (sq[f] + 1) * 4);
            chk("out", bus.out, eo);
         end
         chk("busy", bus.busy, k <= 20 * nacc);
         chk("ovf", bus.ovf,
             (drop_k >= 0) && (k >= drop_k));
      end
      chk("peak_level", peak, peak_exp);
      chk("end_level", bus.level, 0);
   endtask

   initial begin
      int hi;
      n_cmp      = 0;
      n_err      = 0;
      rst_all    = 1'b1;
      bus.enable = 1'b0;
      bus.sym    = '0;
      #3;
      chk("init_out", bus.out, 0);
      chk("init_busy", bus.busy, 0);
      chk("init_level", bus.level, 0);
      do_reset();

      // single sym=0: 4 high, 16 low
      sq = '{0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0};
      run_burst(1, 1, -1, 1);

      // single sym=3: count high clocks directly
      bus.enable = 1'b1;
      bus.sym    = 2'd3;
      hi         = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         bus.enable = 1'b0;
         if (bus.out === 1'b1)
            hi++;
      end
      chk("sym3_high", hi, 16);
      chk("sym3_ovf", bus.ovf, 0);
      chk("sym3_busy", bus.busy, 0);

      // 8-symbol burst, back-to-back frames
      sq = '{0, 1, 2, 3, 3, 2, 1, 0,
             0, 0, 0, 0, 0, 0, 0, 0};
      run_burst(8, 8, -1, 7);

      // 10-symbol burst: 10th dropped at edge 9
      sq = '{1, 2, 3, 0, 1, 2, 3, 0,
             1, 2, 0, 0, 0, 0, 0, 0};
      run_burst(10, 9, 9, 8);
      chk("ovf_held", bus.ovf, 1);

      // reset on third high clock of sym=3
      bus.enable = 1'b1;
      bus.sym    = 2'd3;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      chk("t5_level", bus.level, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         chk("t5_high", bus.out, 1);
      end
      rst_all = 1'b1;
      #1;
      chk("t5_out", bus.out, 0);
      chk("t5_level0", bus.level, 0);
      chk("t5_ovf", bus.ovf, 0);
      chk("t5_busy", bus.busy, 0);
      #1;
      rst_all = 1'b0;
      sq = '{1, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0};
      run_burst(1, 1, -1, 1);

      // idle for 100 clocks
      do_reset();
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         chk("idle_out", bus.out, 0);
         chk("idle_busy", bus.busy, 0);
         chk("idle_level", bus.level, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
